// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe IO endpoint memory responder.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ       = 2'd1,
    WRITE_RESP = 2'd2
  } resp_state_e;

  localparam int MAX_READ_BYTES = 1024;
  // Enough to hold the largest burst: 1024 bytes starting at offset 7 spans 129 beats.
  localparam int BEAT_W = 8;

endpackage

// File: rtl/pcie_io_mem_sram.sv
// Single-port 64-bit SRAM with per-byte write enables and one-cycle registered read.
module pcie_io_mem_sram #(
  parameter int WORDS = 512,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  // rdata only changes on an enabled access, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 8; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pcie_io_mem_responder.sv
// Memory-side responder: serves endpoint read/write requests from local SRAM,
// one response beat per 8-byte word, with a stall-safe output register.
module pcie_io_mem_responder
  import pcie_dma_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int MEM_WORDS = 512
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_req_mem_ready,
  input  logic                 i_req_mem_valid,
  input  logic                 i_req_mem_write,
  input  logic [9:0]           i_req_mem_bytes,
  input  logic [ADDR_BITS-1:0] i_req_mem_addr,
  input  logic [7:0]           i_req_mem_strob,
  input  logic [63:0]          i_req_mem_data,
  input  logic                 i_req_mem_last,
  output logic                 o_resp_mem_valid,
  output logic                 o_resp_mem_last,
  output logic                 o_resp_mem_fault,
  output logic [ADDR_BITS-1:0] o_resp_mem_addr,
  output logic [63:0]          o_resp_mem_data,
  input  logic                 i_resp_mem_ready,
  output resp_state_e          o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a response with valid=1 and ready=0 holds every field unchanged until accepted.

  localparam int WORD_BITS = ADDR_BITS - 3;
  localparam int RAM_AW    = $clog2(MEM_WORDS);

  function automatic logic word_fault(input logic [WORD_BITS-1:0] w);
    return 32'(w) >= MEM_WORDS;
  endfunction

  resp_state_e            state_q, state_d;
  logic [BEAT_W-1:0]      beats_left_q;
  logic [WORD_BITS-1:0]   word_q;
  logic                   first_q;
  logic [ADDR_BITS-1:0]   first_addr_q;

  // Stage between RAM read issue and the output register.
  logic                   p_valid_q, p_last_q, p_fault_q;
  logic [ADDR_BITS-1:0]   p_addr_q;

  logic                   resp_valid_q, resp_last_q, resp_fault_q;
  logic [ADDR_BITS-1:0]   resp_addr_q;
  logic [63:0]            resp_data_q;

  logic                   req_fire, resp_fire, out_free, p_move, issue, wr_fire;
  logic [WORD_BITS-1:0]   req_word;
  logic                   req_fault;
  logic [10:0]            req_len, req_span;
  logic [BEAT_W-1:0]      req_beats;
  logic                   ram_en;
  logic [7:0]             ram_we;
  logic [RAM_AW-1:0]      ram_addr;
  logic [63:0]            ram_rdata;

  assign o_req_mem_ready = (state_q == IDLE) && !resp_valid_q;
  assign req_fire  = o_req_mem_ready && i_req_mem_valid;
  assign resp_fire = resp_valid_q && i_resp_mem_ready;
  assign out_free  = !resp_valid_q || i_resp_mem_ready;
  assign p_move    = p_valid_q && out_free;
  assign issue     = (state_q == READ) && (beats_left_q != '0) && (!p_valid_q || p_move);

  assign req_word  = i_req_mem_addr[ADDR_BITS-1:3];
  assign req_fault = word_fault(req_word);
  assign wr_fire   = req_fire && i_req_mem_write && !req_fault;

  // 11-bit span arithmetic: offset within the first word plus length, rounded up.
  assign req_len   = (i_req_mem_bytes == 10'd0) ? 11'(MAX_READ_BYTES) : {1'b0, i_req_mem_bytes};
  assign req_span  = {8'd0, i_req_mem_addr[2:0]} + req_len + 11'd7;
  assign req_beats = req_span[10:3];

  assign ram_en   = issue || wr_fire;
  assign ram_we   = wr_fire ? i_req_mem_strob : 8'h00;
  assign ram_addr = req_fire ? req_word[RAM_AW-1:0] : word_q[RAM_AW-1:0];

  pcie_io_mem_sram #(
    .WORDS (MEM_WORDS),
    .AW    (RAM_AW)
  ) u_sram (
    .clk   (i_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (i_req_mem_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req_fire) state_d = i_req_mem_write ? WRITE_RESP : READ;
      READ:       if (resp_fire && resp_last_q) state_d = IDLE;
      WRITE_RESP: if (resp_fire) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      word_q       <= '0;
      first_q      <= 1'b0;
      first_addr_q <= '0;
      p_valid_q    <= 1'b0;
      p_last_q     <= 1'b0;
      p_fault_q    <= 1'b0;
      p_addr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q <= state_d;

      if (req_fire && !i_req_mem_write) begin
        word_q       <= req_word;
        beats_left_q <= req_beats;
        first_q      <= 1'b1;
        first_addr_q <= i_req_mem_addr;
      end

      if (issue) begin
        word_q       <= word_q + 1'b1;
        beats_left_q <= beats_left_q - 1'b1;
        first_q      <= 1'b0;
        p_valid_q    <= 1'b1;
        p_addr_q     <= first_q ? first_addr_q : {word_q, 3'b000};
        p_last_q     <= (beats_left_q == BEAT_W'(1));
        p_fault_q    <= word_fault(word_q);
      end else if (p_move) begin
        p_valid_q <= 1'b0;
      end

      // ram_rdata still holds the staged beat here even if a new read issues this edge.
      if (req_fire && i_req_mem_write) begin
        resp_valid_q <= 1'b1;
        resp_last_q  <= i_req_mem_last;
        resp_fault_q <= req_fault;
        resp_addr_q  <= i_req_mem_addr;
        resp_data_q  <= '0;
      end else if (p_move) begin
        resp_valid_q <= 1'b1;
        resp_last_q  <= p_last_q;
        resp_fault_q <= p_fault_q;
        resp_addr_q  <= p_addr_q;
        resp_data_q  <= p_fault_q ? 64'd0 : ram_rdata;
      end else if (resp_fire) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign o_resp_mem_valid = resp_valid_q;
  assign o_resp_mem_last  = resp_last_q;
  assign o_resp_mem_fault = resp_fault_q;
  assign o_resp_mem_addr  = resp_addr_q;
  assign o_resp_mem_data  = resp_data_q;
  assign o_dbg_state      = state_q;

endmodule
